// File: rtl/zint_ctrl.sv
// ZX-bus interrupt controller: synchronised sources, sticky pending bits,
// a lowest-index-first priority vector and a level-follow or timed-pulse INT drive.
module zint_ctrl #(
    parameter int NSRC        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 32
) (
    input  logic            fclk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_in,
    input  logic [NSRC-1:0] src_ena,
    input  logic [NSRC-1:0] src_edge,
    input  logic            master_ena,
    input  logic            pulse_mode,
    input  logic            clr_stb,
    input  logic [NSRC-1:0] clr_mask,
    output logic [NSRC-1:0] pending,
    output logic            vec_valid,
    output logic [2:0]      vec,
    output logic            internal_int,
    output logic            zint_oe
);

    typedef enum logic [1:0] {IDLE, PULSE, ARMED} state_t;

    logic [NSRC-1:0] sync_q [SYNC_STAGES];
    logic [NSRC-1:0] s, s_d, edge_q;
    logic [NSRC-1:0] rise, clr, mode_chg, pend_nxt;
    logic            new_evt, pmode_q;
    state_t          state, state_nxt;
    logic [7:0]      cnt, cnt_nxt;
    logic            oe_nxt;

    function automatic logic [2:0] prio_enc(input logic [NSRC-1:0] p);
        logic [2:0] idx;
        idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (p[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            s_d <= '0;
        end else begin
            sync_q[0] <= src_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            s_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign rise     = s & ~s_d & src_ena;
    assign clr      = ({NSRC{clr_stb}} & clr_mask) | ~src_ena;
    assign mode_chg = src_edge ^ edge_q;

    // Edge sources hold until cleared (a same-cycle set wins); level sources follow s.
    assign pend_nxt = ~mode_chg & ((src_edge & (rise | (pending & ~clr)))
                                 | (~src_edge & s & src_ena));

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            vec       <= '0;
            vec_valid <= 1'b0;
            new_evt   <= 1'b0;
            edge_q    <= '0;
            pmode_q   <= 1'b0;
        end else begin
            pending   <= pend_nxt;
            vec       <= prio_enc(pend_nxt);
            vec_valid <= |pend_nxt;
            new_evt   <= |(pend_nxt & ~pending);
            edge_q    <= src_edge;
            pmode_q   <= pulse_mode;
        end
    end

    assign internal_int = vec_valid;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        oe_nxt    = 1'b0;
        if (!pulse_mode) begin
            state_nxt = IDLE;
            oe_nxt    = vec_valid & master_ena;
        end else if (!master_ena || !pmode_q) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (vec_valid) begin
                        state_nxt = PULSE;
                        cnt_nxt   = 8'(PULSE_LEN - 1);
                        oe_nxt    = 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == 8'd0) begin
                        state_nxt = ARMED;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                        oe_nxt  = 1'b1;
                    end
                end
                ARMED: begin
                    // Only an event seen after the pulse ended may re-trigger.
                    if (new_evt) begin
                        state_nxt = PULSE;
                        cnt_nxt   = 8'(PULSE_LEN - 1);
                        oe_nxt    = 1'b1;
                    end else if (!vec_valid) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            zint_oe <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            zint_oe <= oe_nxt;
        end
    end

endmodule

// File: tb/tb_zint_ctrl.sv
// Directed bench for zint_ctrl: vector table for latch/clear/priority/level behaviour,
// hand sequences for the pulse FSM, gating and asynchronous reset.
module tb_zint_ctrl;

    logic       fclk = 1'b0;
    logic       rst;
    logic [3:0] src_in, src_ena, src_edge, clr_mask;
    logic       master_ena, pulse_mode, clr_stb;
    logic [3:0] pending;
    logic       vec_valid, internal_int, zint_oe;
    logic [2:0] vec;

    int n_vec = 0;
    int n_err = 0;

    zint_ctrl #(.NSRC(4), .SYNC_STAGES(2), .PULSE_LEN(32)) dut (
        .fclk(fclk), .rst(rst), .src_in(src_in), .src_ena(src_ena), .src_edge(src_edge),
        .master_ena(master_ena), .pulse_mode(pulse_mode), .clr_stb(clr_stb), .clr_mask(clr_mask),
        .pending(pending), .vec_valid(vec_valid), .vec(vec), .internal_int(internal_int),
        .zint_oe(zint_oe)
    );

    always #5 fclk = ~fclk;

    typedef struct {
        logic [3:0] in, ena, edg;
        logic       clr;
        logic [3:0] mask, pend;
        logic [2:0] vec;
        logic       oe;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] in, ena, edg, input logic clr, input logic [3:0] mask,
                       input logic [3:0] pend, input logic [2:0] v, input logic oe);
        vec_t r;
        r.in = in; r.ena = ena; r.edg = edg; r.clr = clr; r.mask = mask;
        r.pend = pend; r.vec = v; r.oe = oe;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge fclk);
        #1;
    endtask

    task automatic run_len(output int n);
        n = 0;
        while (zint_oe === 1'b1 && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic fire(input logic [3:0] bits);
        src_in = bits; step(); step();
        src_in = 4'h0; step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n, high;

        // Reset with every request high but all sources disabled
        rst = 1'b1; src_in = 4'hF; src_ena = 4'h0; src_edge = 4'hF;
        master_ena = 1'b1; pulse_mode = 1'b0; clr_stb = 1'b0; clr_mask = 4'h0;
        step(); step(); step();
        chk("rst_pending", 8'(pending), 8'h0);
        chk("rst_vec", 8'(vec), 8'h0);
        chk("rst_vec_valid", 8'(vec_valid), 8'h0);
        chk("rst_internal_int", 8'(internal_int), 8'h0);
        chk("rst_zint_oe", 8'(zint_oe), 8'h0);
        rst = 1'b0;
        step(); step(); step(); step();
        chk("disabled_pending", 8'(pending), 8'h0);
        chk("disabled_oe", 8'(zint_oe), 8'h0);
        src_in = 4'h0;
        step(); step(); step();

        //   in     ena    edge  clr  mask   pend   vec  oe
        add(4'h0, 4'hF, 4'hF, 0, 4'h0, 4'h0, 3'd0, 0);
        add(4'h4, 4'hF, 4'hF, 0, 4'h0, 4'h0, 3'd0, 0);
        add(4'h4, 4'hF, 4'hF, 0, 4'h0, 4'h0, 3'd0, 0);
        add(4'h0, 4'hF, 4'hF, 0, 4'h0, 4'h4, 3'd2, 0);
        add(4'h0, 4'hF, 4'hF, 0, 4'h0, 4'h4, 3'd2, 1);
        add(4'h0, 4'hF, 4'hF, 1, 4'h4, 4'h0, 3'd0, 1);
        add(4'h0, 4'hF, 4'hF, 0, 4'h0, 4'h0, 3'd0, 0);
        add(4'h4, 4'hF, 4'hF, 0, 4'h0, 4'h0, 3'd0, 0);
        add(4'h4, 4'hF, 4'hF, 0, 4'h0, 4'h0, 3'd0, 0);
        add(4'h0, 4'hF, 4'hF, 0, 4'h0, 4'h4, 3'd2, 0);
        add(4'h0, 4'hF, 4'hF, 0, 4'h0, 4'h4, 3'd2, 1);
        add(4'h4, 4'hF, 4'hF, 0, 4'h0, 4'h4, 3'd2, 1);
        add(4'h4, 4'hF, 4'hF, 0, 4'h0, 4'h4, 3'd2, 1);
        add(4'h0, 4'hF, 4'hF, 1, 4'h4, 4'h4, 3'd2, 1);   // clear meets new edge: set wins
        add(4'h0, 4'hF, 4'hF, 0, 4'h0, 4'h4, 3'd2, 1);
        add(4'h0, 4'hF, 4'hF, 1, 4'h4, 4'h0, 3'd0, 1);
        add(4'h0, 4'hF, 4'hF, 0, 4'h0, 4'h0, 3'd0, 0);
        add(4'hA, 4'hF, 4'hF, 0, 4'h0, 4'h0, 3'd0, 0);
        add(4'hA, 4'hF, 4'hF, 0, 4'h0, 4'h0, 3'd0, 0);
        add(4'h0, 4'hF, 4'hF, 0, 4'h0, 4'hA, 3'd1, 0);
        add(4'h0, 4'hF, 4'hF, 1, 4'h2, 4'h8, 3'd3, 1);
        add(4'h0, 4'hF, 4'hF, 1, 4'h8, 4'h0, 3'd0, 1);
        add(4'h0, 4'hF, 4'hF, 0, 4'h0, 4'h0, 3'd0, 0);
        add(4'h1, 4'hF, 4'hF, 0, 4'h0, 4'h0, 3'd0, 0);
        add(4'h1, 4'hF, 4'hF, 0, 4'h0, 4'h0, 3'd0, 0);
        add(4'h0, 4'hF, 4'hF, 0, 4'h0, 4'h1, 3'd0, 0);
        add(4'h0, 4'hE, 4'hF, 0, 4'h0, 4'h0, 3'd0, 1);   // disable clears edge pending
        add(4'h0, 4'hF, 4'hF, 0, 4'h0, 4'h0, 3'd0, 0);
        add(4'h1, 4'hF, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0);   // level mode
        add(4'h1, 4'hF, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0);
        add(4'h1, 4'hF, 4'h0, 0, 4'h0, 4'h1, 3'd0, 0);
        add(4'h1, 4'hF, 4'h0, 1, 4'h1, 4'h1, 3'd0, 1);
        add(4'h0, 4'hF, 4'h0, 0, 4'h0, 4'h1, 3'd0, 1);
        add(4'h0, 4'hF, 4'h0, 0, 4'h0, 4'h1, 3'd0, 1);
        add(4'h0, 4'hF, 4'h0, 0, 4'h0, 4'h0, 3'd0, 1);
        add(4'h0, 4'hF, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0);
        add(4'h4, 4'hF, 4'hF, 0, 4'h0, 4'h0, 3'd0, 0);
        add(4'h4, 4'hF, 4'hF, 0, 4'h0, 4'h0, 3'd0, 0);
        add(4'h0, 4'hF, 4'hF, 0, 4'h0, 4'h4, 3'd2, 0);
        add(4'h0, 4'hF, 4'hB, 0, 4'h0, 4'h0, 3'd0, 1);   // mode change clears bit 2
        add(4'h0, 4'hF, 4'hB, 0, 4'h0, 4'h0, 3'd0, 0);
        add(4'h0, 4'hF, 4'hF, 0, 4'h0, 4'h0, 3'd0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            src_in = tbl[i].in; src_ena = tbl[i].ena; src_edge = tbl[i].edg;
            clr_stb = tbl[i].clr; clr_mask = tbl[i].mask;
            step();
            chk($sformatf("v%0d_pending", i), 8'(pending), 8'(tbl[i].pend));
            chk($sformatf("v%0d_vec", i), 8'(vec), 8'(tbl[i].vec));
            chk($sformatf("v%0d_vec_valid", i), 8'(vec_valid), 8'(tbl[i].pend != 4'h0));
            chk($sformatf("v%0d_internal_int", i), 8'(internal_int), 8'(tbl[i].pend != 4'h0));
            chk($sformatf("v%0d_zint_oe", i), 8'(zint_oe), 8'(tbl[i].oe));
        end
        clr_stb = 1'b0; clr_mask = 4'h0; src_in = 4'h0;

        // Pulse mode: first pulse from IDLE
        pulse_mode = 1'b1;
        step(); step();
        fire(4'h1);
        chk("p1_pending", 8'(pending), 8'h1);
        chk("p1_oe_before", 8'(zint_oe), 8'h0);
        step();
        chk("p1_oe_start", 8'(zint_oe), 8'h1);
        run_len(n);
        chk("p1_width", 8'(n), 8'd32);
        chk("p1_pending_after", 8'(pending), 8'h1);

        // Fresh event while ARMED re-triggers
        fire(4'h2);
        chk("p2_pending", 8'(pending), 8'h3);
        chk("p2_oe_before", 8'(zint_oe), 8'h0);
        step();
        chk("p2_oe_start", 8'(zint_oe), 8'h1);
        run_len(n);
        chk("p2_width", 8'(n), 8'd32);

        // Event during a pulse: no extension, no second pulse
        clr_stb = 1'b1; clr_mask = 4'hF; step();
        clr_stb = 1'b0; clr_mask = 4'h0;
        chk("p3_cleared", 8'(pending), 8'h0);
        step(); step();
        fire(4'h1);
        high = 0;
        for (int i = 0; i < 80; i++) begin
            if (i == 4) src_in = 4'h4;
            if (i == 6) src_in = 4'h0;
            step();
            if (zint_oe === 1'b1) high++;
        end
        chk("p3_high_cycles", 8'(high), 8'd32);
        chk("p3_pending", 8'(pending), 8'h5);

        // master_ena drop mid-pulse, then async reset mid-pulse
        clr_stb = 1'b1; clr_mask = 4'hF; step();
        clr_stb = 1'b0; clr_mask = 4'h0;
        step(); step();
        fire(4'h1);
        step();
        chk("g_oe_start", 8'(zint_oe), 8'h1);
        step(); step(); step(); step();
        master_ena = 1'b0;
        step();
        chk("g_oe_gated", 8'(zint_oe), 8'h0);
        chk("g_internal_int", 8'(internal_int), 8'h1);
        master_ena = 1'b1;
        step();
        chk("g_oe_restart", 8'(zint_oe), 8'h1);
        rst = 1'b1;
        #1;
        chk("r_oe_async", 8'(zint_oe), 8'h0);
        chk("r_pending_async", 8'(pending), 8'h0);
        chk("r_vec_valid_async", 8'(vec_valid), 8'h0);
        step();
        rst = 1'b0;
        step(); step();
        chk("r_oe_after", 8'(zint_oe), 8'h0);
        chk("r_pending_after", 8'(pending), 8'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
